// File: rtl/station_share_aggregator.sv
// Collects per-station percentage_stored reports, ages out silent stations and periodically
// publishes the summed share (R) and the station count (G) from one consistent table scan.
module station_share_aggregator #(
    parameter int MAX_STATIONS   = 16,
    parameter int ID_W           = 4,
    parameter int PUBLISH_PERIOD = 60,
    parameter int STALE_SCANS    = 4,
    parameter int INT            = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              report_valid,
    output logic              report_ready,
    input  logic [ID_W-1:0]   report_station_id,
    input  logic [INT:0]      report_percentage,
    input  logic              report_leave,
    output logic [INT:0]      total_percentage_stored,
    output logic [INT:0]      number_of_stations,
    output logic              no_stations,
    output logic              totals_valid,
    output logic              overflow,
    output logic              bad_id
);

    localparam int DATA_W = INT + 1;
    localparam int IDX_W  = (MAX_STATIONS > 1) ? $clog2(MAX_STATIONS) : 1;
    localparam int TMR_W  = (PUBLISH_PERIOD > 1) ? $clog2(PUBLISH_PERIOD) : 1;
    localparam int CNT_W  = $clog2(MAX_STATIONS + 1);
    localparam int AGE_W  = (STALE_SCANS > 1) ? $clog2(STALE_SCANS + 1) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, PUBLISH} state_t;

    state_t             state;
    logic [TMR_W-1:0]   timer;
    logic [IDX_W-1:0]   idx;
    logic               active [MAX_STATIONS];
    logic [DATA_W-1:0]  pct    [MAX_STATIONS];
    logic [AGE_W-1:0]   age    [MAX_STATIONS];
    logic [DATA_W-1:0]  acc;
    logic [CNT_W-1:0]   cnt;
    logic               scan_ovf;

    logic               accept;
    logic               id_ok;
    logic [IDX_W-1:0]   wr_idx;
    logic [AGE_W-1:0]   next_age;
    logic               expire;

    function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[DATA_W] ? {DATA_W{1'b1}} : s[DATA_W-1:0];
    endfunction

    function automatic logic add_carry(input logic [DATA_W-1:0] a,
                                       input logic [DATA_W-1:0] b);
        logic [DATA_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[DATA_W];
    endfunction

    assign accept   = report_valid & report_ready;
    assign id_ok    = ({{(32-ID_W){1'b0}}, report_station_id} < 32'(MAX_STATIONS));
    assign wr_idx   = report_station_id[IDX_W-1:0];
    assign next_age = age[idx] + AGE_W'(1);
    // An entry reaching the stale limit is still counted in this scan, gone from the next.
    assign expire   = (STALE_SCANS != 0) && (next_age == AGE_W'(STALE_SCANS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                   <= IDLE;
            timer                   <= '0;
            idx                     <= '0;
            acc                     <= '0;
            cnt                     <= '0;
            scan_ovf                <= 1'b0;
            for (int i = 0; i < MAX_STATIONS; i++) begin
                active[i] <= 1'b0;
                pct[i]    <= '0;
                age[i]    <= '0;
            end
            total_percentage_stored <= '0;
            number_of_stations      <= DATA_W'(1);
            no_stations             <= 1'b1;
            totals_valid            <= 1'b0;
            overflow                <= 1'b0;
            bad_id                  <= 1'b0;
            report_ready            <= 1'b1;
        end else begin
            totals_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!id_ok) begin
                            bad_id <= 1'b1;
                        end else if (report_leave) begin
                            active[wr_idx] <= 1'b0;
                        end else begin
                            active[wr_idx] <= 1'b1;
                            pct[wr_idx]    <= report_percentage;
                            age[wr_idx]    <= '0;
                        end
                    end
                    if (timer == TMR_W'(PUBLISH_PERIOD - 1)) begin
                        state        <= SCAN;
                        timer        <= '0;
                        idx          <= '0;
                        acc          <= '0;
                        cnt          <= '0;
                        scan_ovf     <= 1'b0;
                        report_ready <= 1'b0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                SCAN: begin
                    if (active[idx]) begin
                        acc      <= sat_add(acc, pct[idx]);
                        scan_ovf <= scan_ovf | add_carry(acc, pct[idx]);
                        cnt      <= cnt + CNT_W'(1);
                        age[idx] <= next_age;
                        if (expire) active[idx] <= 1'b0;
                    end
                    if (idx == IDX_W'(MAX_STATIONS - 1)) begin
                        state <= PUBLISH;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                PUBLISH: begin
                    // G is forced to 1 on an empty table so downstream can divide by it safely.
                    if (cnt == '0) begin
                        total_percentage_stored <= '0;
                        number_of_stations      <= DATA_W'(1);
                        no_stations             <= 1'b1;
                    end else begin
                        total_percentage_stored <= acc;
                        number_of_stations      <= DATA_W'(cnt);
                        no_stations             <= 1'b0;
                    end
                    overflow     <= overflow | scan_ovf;
                    totals_valid <= 1'b1;
                    report_ready <= 1'b1;
                    timer        <= '0;
                    state        <= IDLE;
                end
                default: begin
                    state        <= IDLE;
                    report_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_station_share_aggregator.sv
// Directed bench: three instances (baseline, STALE_SCANS=2, INT=7) driven by hand-computed vectors.
module tb_station_share_aggregator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  rid = '0;
    logic [31:0] rpct = '0;
    logic        rlv = 1'b0;

    logic        v_a = 1'b0, v_s = 1'b0, v_o = 1'b0;
    logic        rdy_a, rdy_s, rdy_o;
    logic [31:0] r_a, g_a, r_s, g_s;
    logic [7:0]  r_o, g_o;
    logic        ns_a, ns_s, ns_o, tv_a, tv_s, tv_o;
    logic        ov_a, ov_s, ov_o, bad_a, bad_s, bad_o;

    int          sel = 0;
    logic        rdy_m, ns_m, tv_m, ov_m, bad_m;
    logic [31:0] r_m, g_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    station_share_aggregator #(.MAX_STATIONS(4), .ID_W(3), .PUBLISH_PERIOD(8),
                               .STALE_SCANS(0), .INT(31)) u_a (
        .clk(clk), .rst(rst), .report_valid(v_a), .report_ready(rdy_a),
        .report_station_id(rid), .report_percentage(rpct), .report_leave(rlv),
        .total_percentage_stored(r_a), .number_of_stations(g_a), .no_stations(ns_a),
        .totals_valid(tv_a), .overflow(ov_a), .bad_id(bad_a));

    station_share_aggregator #(.MAX_STATIONS(4), .ID_W(3), .PUBLISH_PERIOD(8),
                               .STALE_SCANS(2), .INT(31)) u_s (
        .clk(clk), .rst(rst), .report_valid(v_s), .report_ready(rdy_s),
        .report_station_id(rid), .report_percentage(rpct), .report_leave(rlv),
        .total_percentage_stored(r_s), .number_of_stations(g_s), .no_stations(ns_s),
        .totals_valid(tv_s), .overflow(ov_s), .bad_id(bad_s));

    station_share_aggregator #(.MAX_STATIONS(4), .ID_W(3), .PUBLISH_PERIOD(8),
                               .STALE_SCANS(0), .INT(7)) u_o (
        .clk(clk), .rst(rst), .report_valid(v_o), .report_ready(rdy_o),
        .report_station_id(rid), .report_percentage(rpct[7:0]), .report_leave(rlv),
        .total_percentage_stored(r_o), .number_of_stations(g_o), .no_stations(ns_o),
        .totals_valid(tv_o), .overflow(ov_o), .bad_id(bad_o));

    always_comb begin
        rdy_m = rdy_a; r_m = r_a; g_m = g_a; ns_m = ns_a; tv_m = tv_a; ov_m = ov_a; bad_m = bad_a;
        case (sel)
            1: begin
                rdy_m = rdy_s; r_m = r_s; g_m = g_s; ns_m = ns_s;
                tv_m = tv_s; ov_m = ov_s; bad_m = bad_s;
            end
            2: begin
                rdy_m = rdy_o; r_m = {24'd0, r_o}; g_m = {24'd0, g_o}; ns_m = ns_o;
                tv_m = tv_o; ov_m = ov_o; bad_m = bad_o;
            end
            default: ;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_valid(input logic v);
        case (sel)
            1:       v_s = v;
            2:       v_o = v;
            default: v_a = v;
        endcase
    endtask

    // Holds valid until the selected instance accepts, returns #1 after the accepting edge.
    task automatic send(input logic [2:0] id, input logic [31:0] p, input logic lv);
        int n;
        rid = id; rpct = p; rlv = lv;
        set_valid(1'b1);
        n = 0;
        while (!rdy_m && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_eq("send_timeout", {31'd0, rdy_m}, 32'd1);
        @(posedge clk); #1;
        set_valid(1'b0);
    endtask

    // Returns #1 after the edge where totals_valid rises; n reports edges consumed.
    task automatic wait_tv(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!tv_m && n < 100);
        if (!tv_m) check_eq("tv_timeout", {31'd0, tv_m}, 32'd1);
    endtask

    task automatic check_out(input string tag, input logic [31:0] r, input logic [31:0] g,
                             input logic ns);
        check_eq({tag, "_R"}, r_m, r);
        check_eq({tag, "_G"}, g_m, g);
        check_eq({tag, "_ns"}, {31'd0, ns_m}, {31'd0, ns});
    endtask

    initial begin
        int n;
        int low;

        // 1: reset state and publish cadence on the baseline instance
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sel = 0;
        check_out("rst", 32'd0, 32'd1, 1'b1);
        check_eq("rst_tv", {31'd0, tv_m}, 32'd0);
        check_eq("rst_ovf", {31'd0, ov_m}, 32'd0);
        check_eq("rst_bad", {31'd0, bad_m}, 32'd0);
        check_eq("rst_ready", {31'd0, rdy_m}, 32'd1);
        wait_tv(n);
        check_eq("first_tv_cycle", n, 32'd13);
        check_out("empty1", 32'd0, 32'd1, 1'b1);
        wait_tv(n);
        check_eq("second_tv_period", n, 32'd13);
        check_out("empty2", 32'd0, 32'd1, 1'b1);

        // 2: three stations
        send(3'd0, 32'd300, 1'b0);
        send(3'd1, 32'd500, 1'b0);
        send(3'd2, 32'd100, 1'b0);
        wait_tv(n);
        check_out("three", 32'd900, 32'd3, 1'b0);
        @(posedge clk); #1;
        check_eq("tv_pulse", {31'd0, tv_m}, 32'd0);

        // 3: update then leave in one window, then leave of an inactive id
        send(3'd1, 32'd700, 1'b0);
        send(3'd1, 32'd0, 1'b1);
        wait_tv(n);
        check_out("leave", 32'd400, 32'd2, 1'b0);
        send(3'd3, 32'd0, 1'b1);
        wait_tv(n);
        check_out("leave_inact", 32'd400, 32'd2, 1'b0);

        // 6a: out-of-range id
        send(3'd5, 32'd999, 1'b0);
        check_eq("bad_id", {31'd0, bad_m}, 32'd1);
        wait_tv(n);
        check_out("bad_nochg", 32'd400, 32'd2, 1'b0);

        // 6b: report raised at scan start waits through SCAN and PUBLISH
        repeat (8) @(posedge clk);
        #1;
        check_eq("scan_ready", {31'd0, rdy_m}, 32'd0);
        rid = 3'd3; rpct = 32'd40; rlv = 1'b0;
        v_a = 1'b1;
        low = 0;
        while (low < 50) begin
            @(negedge clk);
            if (rdy_m) break;
            low++;
        end
        check_eq("ready_low_cycles", low, 32'd5);
        check_eq("accept_cycle_tv", {31'd0, tv_m}, 32'd1);
        @(posedge clk); #1;
        v_a = 1'b0;
        wait_tv(n);
        check_out("held_rep", 32'd440, 32'd3, 1'b0);

        // 4: ageing with STALE_SCANS=2
        sel = 1;
        wait_tv(n);
        send(3'd0, 32'd50, 1'b0);
        wait_tv(n);
        check_out("stale1", 32'd50, 32'd1, 1'b0);
        wait_tv(n);
        check_out("stale2", 32'd50, 32'd1, 1'b0);
        wait_tv(n);
        check_out("stale3", 32'd0, 32'd1, 1'b1);

        // 5: saturation with INT=7
        sel = 2;
        wait_tv(n);
        check_eq("ovf_before", {31'd0, ov_m}, 32'd0);
        send(3'd0, 32'd200, 1'b0);
        send(3'd1, 32'd100, 1'b0);
        wait_tv(n);
        check_out("sat", 32'd255, 32'd2, 1'b0);
        check_eq("ovf_set", {31'd0, ov_m}, 32'd1);
        send(3'd1, 32'd0, 1'b1);
        wait_tv(n);
        check_out("after_sat", 32'd200, 32'd1, 1'b0);
        check_eq("ovf_sticky", {31'd0, ov_m}, 32'd1);

        // 6c: reset in the middle of a scan on the baseline instance
        sel = 0;
        wait_tv(n);
        repeat (10) @(posedge clk);
        #1;
        check_eq("pre_rst_scan", {31'd0, rdy_m}, 32'd0);
        rst = 1'b1;
        #1;
        check_out("midscan_rst", 32'd0, 32'd1, 1'b1);
        check_eq("midscan_bad", {31'd0, bad_m}, 32'd0);
        check_eq("midscan_tv", {31'd0, tv_m}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check_eq("post_rst_ready", {31'd0, rdy_m}, 32'd1);
        wait_tv(n);
        check_eq("post_rst_tv_cycle", n, 32'd13);
        check_out("post_rst", 32'd0, 32'd1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
